scan_chain_ctrl: RTL and testbench

//  Sequences a serial chain of CHAIN_LEN DFF cells, such as a configuration or scan register built from DFF_X* cells.

---
 rtl/scan_chain_pkg.sv | 22 ++
 rtl/scan_chain_ctrl_shreg.sv | 43 ++++
 rtl/scan_chain_ctrl.sv | 100 ++++++++++
 tb/tb_scan_chain_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/scan_chain_pkg.sv
// Shared types and helpers for the scan chain controller.
//   state_t : controller FSM states
//   clog2   : ceiling log2, used to size the shift counter
package scan_chain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    UPDATE,
    RESP
  } state_t;

  // Smallest r with 2**r >= v; v=2 gives 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/scan_chain_ctrl_shreg.sv
// Dual shift register between the controller and the flop chain.
//   ck, rn     : clock, async active-low reset
//   load       : load load_data into the write side
//   load_data  : word to shift into the chain
//   shift_en   : shifts both sides together
//   so         : chain tail, enters the read side at the MSB
//   si         : chain head drive, bit 0 of the write side (a flop)
//   rd_data    : read-back word
module scan_shreg #(
  parameter int unsigned LEN = 16
) (
  input  logic           ck,
  input  logic           rn,
  input  logic           load,
  input  logic [LEN-1:0] load_data,
  input  logic           shift_en,
  input  logic           so,
  output logic           si,
  output logic [LEN-1:0] rd_data
);

  logic [LEN-1:0] wr_q;

  // Write side drains LSB-first; zeros fill behind so SI idles low.
  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      wr_q    <= '0;
      rd_data <= '0;
    end else begin
      if (load) begin
        wr_q <= load_data;
      end else if (shift_en) begin
        wr_q <= {1'b0, wr_q[LEN-1:1]};
      end
      if (shift_en) begin
        rd_data <= {so, rd_data[LEN-1:1]};
      end
    end
  end

  assign si = wr_q[0];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Sequencer for a serial chain of CHAIN_LEN flops: optional capture,
// CHAIN_LEN shift cycles, update strobe, then a read-back response.
//   ck, rn                          : clock, async active-low reset
//   req_valid/req_ready             : request handshake
//   req_capture, req_data           : capture-first flag and write word
//   so / se, si, cap, upd           : chain interface
//   rsp_valid/rsp_ready, rsp_data   : response handshake and read-back
//   busy                            : high outside IDLE
module scan_chain_ctrl
  import scan_chain_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 16
) (
  input  logic                 ck,
  input  logic                 rn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_capture,
  input  logic [CHAIN_LEN-1:0] req_data,
  input  logic                 so,
  output logic                 se,
  output logic                 si,
  output logic                 cap,
  output logic                 upd,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 busy
);

  localparam int unsigned CNT_W = clog2(CHAIN_LEN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;
  logic             shift_c;
  logic             last_c;

  assign accept_c = req_ready && req_valid;
  assign shift_c  = (state_q == SHIFT);
  assign last_c   = (cnt_q == CNT_W'(CHAIN_LEN - 1));

  // Next-state and shift counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = req_capture ? CAPTURE : SHIFT;
      CAPTURE: state_d = SHIFT;
      SHIFT: begin
        if (last_c) begin
          state_d = UPDATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UPDATE:  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; strobes decoded from the next state so they are flops.
  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      se        <= 1'b0;
      cap       <= 1'b0;
      upd       <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_ready <= (state_d == IDLE);
      se        <= (state_d == SHIFT);
      cap       <= (state_d == CAPTURE);
      upd       <= (state_d == UPDATE);
      rsp_valid <= (state_d == RESP);
      busy      <= (state_d != IDLE);
    end
  end

  scan_shreg #(
    .LEN(CHAIN_LEN)
  ) u_shreg (
    .ck        (ck),
    .rn        (rn),
    .load      (accept_c),
    .load_data (req_data),
    .shift_en  (shift_c),
    .so        (so),
    .si        (si),
    .rd_data   (rsp_data)
  );

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with an 8-flop chain model
// (si -> ch[7], so = ch[0], shift right on se, parallel load on cap).
module tb_scan_chain_ctrl;

  localparam int unsigned N = 8;

  logic         ck = 1'b0;
  logic         rn;
  logic         req_valid, req_ready, req_capture;
  logic [N-1:0] req_data;
  logic         so, se, si, cap, upd;
  logic         rsp_valid, rsp_ready;
  logic [N-1:0] rsp_data;
  logic         busy;

  logic [N-1:0] ch, pin, pre_val;
  logic         pre_en;

  int n_vec = 0;
  int n_err = 0;
  logic [N-1:0] exp_q[$];

  always #5 ck = ~ck;

  // Chain model.
  always @(posedge ck) begin
    if (pre_en)   ch <= pre_val;
    else if (cap) ch <= pin;
    else if (se)  ch <= {si, ch[N-1:1]};
  end
  assign so = ch[0];

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .ck(ck), .rn(rn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_capture(req_capture), .req_data(req_data),
    .so(so), .se(se), .si(si), .cap(cap), .upd(upd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // Scoreboard monitor: compares on every response handshake.
  task automatic monitor();
    forever begin
      @(negedge ck);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else chk("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic issue(input logic [N-1:0] d, input logic c);
    req_data    = d;
    req_capture = c;
    req_valid   = 1'b1;
    tick();
    req_valid   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && req_ready && !busy) begin
        done = 1;
        break;
      end
      tick();
    end
    chk("done_in_budget", 32'(done), 32'd1);
  endtask

  initial begin
    logic [N-1:0] d;
    logic [N-1:0] t6 [3];
    rn = 1'b0; req_valid = 1'b0; req_capture = 1'b0; req_data = '0;
    rsp_ready = 1'b0; pin = '0; pre_en = 1'b1; pre_val = '0;
    fork monitor(); join_none

    // 1: reset with random inputs
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'($urandom); req_capture = 1'($urandom);
      req_data = N'($urandom); rsp_ready = 1'($urandom); pin = N'($urandom);
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_outs", {26'd0, se, si, cap, upd, rsp_valid, busy}, 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    end
    req_valid = 1'b0; req_capture = 1'b0; rsp_ready = 1'b1; pre_en = 1'b0;
    rn = 1'b1;
    tick(); tick();
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // 2: no capture, chain 3C, write A5
    pre_en = 1'b1; pre_val = 8'h3C; tick(); pre_en = 1'b0;
    d = 8'hA5;
    exp_q.push_back(8'h3C);
    issue(d, 1'b0);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("t2_si%0d", k), 32'(si), 32'(d[k]));
      chk("t2_se", 32'(se), 32'd1);
      chk("t2_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    chk("t2_upd", {30'd0, upd, se}, 32'd2);
    tick();
    chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();
    chk("t2_chain", 32'(ch), 32'hA5);
    chk("t2_idle", 32'(req_ready), 32'd1);

    // 3: capture 5A, write FF
    pin = 8'h5A;
    exp_q.push_back(8'h5A);
    issue(8'hFF, 1'b1);
    chk("t3_cap", {30'd0, cap, se}, 32'd2);
    tick();
    for (int k = 0; k < N; k++) begin
      chk("t3_se_si", {30'd0, se, si}, 32'd3);
      tick();
    end
    chk("t3_upd", 32'(upd), 32'd1);
    tick();
    chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    wait_done(5);
    chk("t3_chain", 32'(ch), 32'hFF);

    // 4: response stall, second request held off
    rsp_ready = 1'b0; pin = 8'hC3;
    exp_q.push_back(8'hC3);
    issue(8'h55, 1'b1);
    for (int i = 0; i < N + 2; i++) tick();
    req_data = 8'h96; req_capture = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t4_rsp_data", 32'(rsp_data), 32'hC3);
      chk("t4_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    exp_q.push_back(8'h55);
    rsp_ready = 1'b1;
    tick();
    chk("t4_ready_after", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("t4_accepted", {30'd0, busy, req_ready}, 32'd2);
    wait_done(20);
    chk("t4_chain", 32'(ch), 32'h96);

    // 5: reset during shift cycle 4
    issue(8'hF0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    #2 rn = 1'b0;
    #1;
    chk("t5_abort", {26'd0, se, si, cap, upd, rsp_valid, busy}, 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      if (i == 3) rn = 1'b1;
      tick();
      chk("t5_no_upd", 32'(upd), 32'd0);
    end
    chk("t5_chain_partial", 32'(ch), 32'h09);
    exp_q.push_back(8'h09);
    issue(8'h3C, 1'b0);
    wait_done(20);
    chk("t5_chain", 32'(ch), 32'h3C);

    // 6: back-to-back requests every N+3 cycles
    t6[0] = 8'h11; t6[1] = 8'h22; t6[2] = 8'h33;
    exp_q.push_back(8'h3C); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    req_capture = 1'b0; req_data = t6[0]; req_valid = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      req_data = (r < 2) ? t6[r+1] : 8'h00;
      if (r == 2) req_valid = 1'b0;
      for (int i = 0; i < N + 1; i++) tick();
      chk("t6_rsp_valid", {30'd0, rsp_valid, req_ready}, 32'd2);
      tick();
      chk("t6_req_ready", {30'd0, req_ready, busy}, 32'd2);
      tick();
      if (r < 2) chk("t6_accepted", 32'(busy), 32'd1);
    end
    wait_done(20);
    chk("t6_chain", 32'(ch), 32'h33);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
